read_data_return: RTL and testbench

- Return-path counterpart to the bus write-data mux. It routes a slave's read data back to whichever of the two masters issued the read.
- Latches the master target when the arbiter starts a read, waits for slave read data (with timeout), then holds it in a per-master output register under a valid/ready handshake.
- Sits between the slave read-data bus and the two master read ports.

---
 rtl/read_data_return_if.sv | 37 +++
 rtl/read_data_return.sv | 102 ++++++++++
 tb/tb_read_data_return.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/read_data_return_if.sv
// Read-return bus bundle: arbiter select/request, slave read data and both master read ports.
// Latency: none, only wiring.
// Backpressure: carries the m0/m1 rready signals back from the masters.
//
// Signals:
//   sel, rd_req            arbiter select and read-grant pulse
//   slv_rdata, slv_rvalid  slave read data
//   mX_rdata/rvalid/rready per-master read port
//   busy, timeout_err      status back to the arbiter
interface read_data_return_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        sel;
    logic              rd_req;
    logic [DATA_W-1:0] slv_rdata;
    logic              slv_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;
    logic              m0_rready;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;
    logic              m1_rready;
    logic              busy;
    logic              timeout_err;

    // Environment side: arbiter, slave and masters.
    modport master (
        output sel, rd_req, slv_rdata, slv_rvalid, m0_rready, m1_rready,
        input  m0_rdata, m0_rvalid, m1_rdata, m1_rvalid, busy, timeout_err
    );

    // Return-path block side.
    modport slave (
        input  sel, rd_req, slv_rdata, slv_rvalid, m0_rready, m1_rready,
        output m0_rdata, m0_rvalid, m1_rdata, m1_rvalid, busy, timeout_err
    );
endinterface

// File: rtl/read_data_return.sv
// Routes slave read data back to the master that issued the read, all-ones on a slave timeout.
// Latency: rd_req at N, slv_rvalid at N+k (k>=1) -> target rvalid from N+k+1 (minimum 2 cycles).
// Backpressure: target rdata/rvalid held until its rready; new rd_req only accepted back in IDLE.
//
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   read_data_return_if.slave (sel, rd_req, slv_*, m0_*, m1_*, busy, timeout_err)
module read_data_return #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    read_data_return_if.slave     bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SLV = 2'd1,
        ST_DELIVER  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_target;      // 0: master 0, 1: master 1
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_timeout_err;

    logic              w_tgt_rready;
    logic              w_cnt_done;
    logic              w_load;
    logic              w_load_to;
    logic [DATA_W-1:0] w_load_dat;

    // Only the target's rready matters; the other master is ignored.
    assign w_tgt_rready = r_target ? bus.m1_rready : bus.m0_rready;
    assign w_cnt_done   = (r_cnt == CNT_W'(TIMEOUT - 1));
    // slv_rvalid wins over a timeout landing in the same cycle.
    assign w_load       = (r_state == ST_WAIT_SLV) && (bus.slv_rvalid || w_cnt_done);
    assign w_load_to    = (r_state == ST_WAIT_SLV) && !bus.slv_rvalid && w_cnt_done;
    assign w_load_dat   = bus.slv_rvalid ? bus.slv_rdata : '1;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (bus.rd_req)                    w_state_nxt = ST_WAIT_SLV;
            ST_WAIT_SLV: if (bus.slv_rvalid || w_cnt_done)  w_state_nxt = ST_DELIVER;
            ST_DELIVER:  if (w_tgt_rready)                  w_state_nxt = ST_IDLE;
            default:                                        w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decodes of registered state, so reset clears them without a clock edge.
    always_comb begin
        bus.m0_rvalid   = (r_state == ST_DELIVER) && !r_target;
        bus.m1_rvalid   = (r_state == ST_DELIVER) &&  r_target;
        bus.busy        = (r_state != ST_IDLE);
        bus.m0_rdata    = r_m0_rdata;
        bus.m1_rdata    = r_m1_rdata;
        bus.timeout_err = r_timeout_err;
    end

    // Target, timeout counter and per-master data registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_target      <= 1'b0;
            r_cnt         <= '0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_load_to;
            if ((r_state == ST_IDLE) && bus.rd_req) begin
                // Same select encoding as the write-data mux: only 2'd1 means master 0.
                r_target <= (bus.sel != 2'd1);
                r_cnt    <= '0;
            end else if ((r_state == ST_WAIT_SLV) && !bus.slv_rvalid && !w_cnt_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load && !r_target) begin
                r_m0_rdata <= w_load_dat;
            end
            if (w_load && r_target) begin
                r_m1_rdata <= w_load_dat;
            end
        end
    end
endmodule

// File: tb/tb_read_data_return.sv
module tb_read_data_return;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    typedef struct packed {
        logic        tgt;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    read_data_return_if #(.DATA_W(32)) bus_if ();

    read_data_return #(.DATA_W(32), .TIMEOUT(15)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each tick lands 1 time unit after the rising edge: inputs driven here
    // are sampled on the next edge, outputs read here belong to this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic tgt, input logic [31:0] dat, input logic err);
        exp_t e;
        e.tgt = tgt;
        e.dat = dat;
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Called in a cycle where a delivery is expected: pop and compare.
    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.tgt == 1'b0) begin
                chk({tag, "_m0_rvalid"}, 64'(bus_if.m0_rvalid), 64'd1);
                chk({tag, "_m1_rvalid"}, 64'(bus_if.m1_rvalid), 64'd0);
                chk({tag, "_m0_rdata"},  64'(bus_if.m0_rdata),  64'(e.dat));
            end else begin
                chk({tag, "_m1_rvalid"}, 64'(bus_if.m1_rvalid), 64'd1);
                chk({tag, "_m0_rvalid"}, 64'(bus_if.m0_rvalid), 64'd0);
                chk({tag, "_m1_rdata"},  64'(bus_if.m1_rdata),  64'(e.dat));
            end
            chk({tag, "_timeout_err"}, 64'(bus_if.timeout_err), 64'(e.err));
        end
    endtask

    task automatic wait_deliver(input string tag, input int budget);
        int n;
        n = 0;
        while (!(bus_if.m0_rvalid || bus_if.m1_rvalid) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_arrived"}, 64'(bus_if.m0_rvalid || bus_if.m1_rvalid), 64'd1);
        if (bus_if.m0_rvalid || bus_if.m1_rvalid) sb_check(tag);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},      64'(bus_if.busy),      64'd0);
        chk({tag, "_m0_rvalid"}, 64'(bus_if.m0_rvalid), 64'd0);
        chk({tag, "_m1_rvalid"}, 64'(bus_if.m1_rvalid), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn                = 1'b0;
        bus_if.sel          = 2'd0;
        bus_if.rd_req       = 1'b0;
        bus_if.slv_rdata    = '0;
        bus_if.slv_rvalid   = 1'b0;
        bus_if.m0_rready    = 1'b0;
        bus_if.m1_rready    = 1'b0;

        // ---------------- reset values
        tick();
        tick();
        chk_idle("rst");
        chk("rst_m0_rdata", 64'(bus_if.m0_rdata),    64'd0);
        chk("rst_m1_rdata", 64'(bus_if.m1_rdata),    64'd0);
        chk("rst_terr",     64'(bus_if.timeout_err), 64'd0);
        rstn = 1'b1;
        tick();

        // ---------------- read to master 0
        bus_if.sel = 2'd1; bus_if.rd_req = 1'b1; bus_if.m0_rready = 1'b1;     // cycle 0
        sb_push(1'b0, 32'h1234_5678, 1'b0);
        tick(); bus_if.rd_req = 1'b0;                                           // cycle 1
        chk("t1_busy_c1", 64'(bus_if.busy), 64'd1);
        tick();                                                                 // cycle 2
        tick(); bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'h1234_5678;     // cycle 3
        chk("t1_m0_rvalid_c3", 64'(bus_if.m0_rvalid), 64'd0);
        chk("t1_busy_c3",      64'(bus_if.busy),      64'd1);
        tick(); bus_if.slv_rvalid = 1'b0;                                       // cycle 4
        sb_check("t1");
        chk("t1_busy_c4", 64'(bus_if.busy), 64'd1);
        tick();                                                                 // cycle 5
        chk_idle("t1_c5");

        // ---------------- read to master 1 with backpressure
        bus_if.sel = 2'd2; bus_if.rd_req = 1'b1; bus_if.m1_rready = 1'b0;     // cycle 0
        sb_push(1'b1, 32'hCAFE_0001, 1'b0);
        tick(); bus_if.rd_req = 1'b0;                                           // cycle 1
        bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'hCAFE_0001;
        tick(); bus_if.slv_rvalid = 1'b0;                                       // cycle 2
        sb_check("t2");
        for (int i = 0; i < 5; i++) begin                                       // cycles 2..6
            chk("t2_stall_m1_rvalid", 64'(bus_if.m1_rvalid), 64'd1);
            chk("t2_stall_m1_rdata",  64'(bus_if.m1_rdata),  64'hCAFE_0001);
            chk("t2_stall_m0_rvalid", 64'(bus_if.m0_rvalid), 64'd0);
            // Stray request, select change and slave data mid-stall must be ignored.
            bus_if.rd_req     = (i == 1);
            bus_if.sel        = (i == 1) ? 2'd1 : 2'd2;
            bus_if.slv_rvalid = (i == 2);
            bus_if.slv_rdata  = 32'hDEAD_0000;
            tick();
        end
        bus_if.m1_rready = 1'b1;                                                // cycle 7
        chk("t2_rise_m1_rvalid", 64'(bus_if.m1_rvalid), 64'd1);
        chk("t2_rise_m1_rdata",  64'(bus_if.m1_rdata),  64'hCAFE_0001);
        chk("t2_m0_rdata_kept",  64'(bus_if.m0_rdata),  64'h1234_5678);
        tick();                                                                 // cycle 8
        chk_idle("t2_c8");

        // ---------------- timeout, no slave response
        bus_if.sel = 2'd1; bus_if.rd_req = 1'b1;                                // cycle 0
        sb_push(1'b0, 32'hFFFF_FFFF, 1'b1);
        tick(); bus_if.rd_req = 1'b0;
        for (int i = 1; i <= 15; i++) begin                                     // cycles 1..15
            chk("t3_wait_terr",      64'(bus_if.timeout_err), 64'd0);
            chk("t3_wait_m0_rvalid", 64'(bus_if.m0_rvalid),   64'd0);
            if (i < 15) tick();
        end
        tick();                                                                 // cycle 16
        sb_check("t3_to");
        tick();                                                                 // cycle 17
        chk("t3_terr_one_cycle", 64'(bus_if.timeout_err), 64'd0);
        chk_idle("t3_c17");

        // ---------------- slave response in the timeout cycle
        bus_if.sel = 2'd1; bus_if.rd_req = 1'b1;                                // cycle 0
        sb_push(1'b0, 32'h5A5A_0F0F, 1'b0);
        tick(); bus_if.rd_req = 1'b0;                                           // cycle 1
        for (int i = 2; i <= 15; i++) tick();                                   // cycle 15
        bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'h5A5A_0F0F;
        tick(); bus_if.slv_rvalid = 1'b0;                                       // cycle 16
        sb_check("t3_late");
        tick();
        chk("t3_late_terr", 64'(bus_if.timeout_err), 64'd0);
        chk_idle("t3_late_idle");

        // ---------------- ignored slv_rvalid alongside rd_req, and in IDLE
        bus_if.sel = 2'd0; bus_if.rd_req = 1'b1; bus_if.m1_rready = 1'b1;     // cycle 0
        bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'hDEAD_BEEF;
        sb_push(1'b1, 32'hAAAA_5555, 1'b0);
        tick(); bus_if.rd_req = 1'b0; bus_if.slv_rvalid = 1'b0;                 // cycle 1
        chk("t4_c1_m1_rvalid", 64'(bus_if.m1_rvalid), 64'd0);
        tick(); bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'hAAAA_5555;     // cycle 2
        chk("t4_c2_m1_rvalid", 64'(bus_if.m1_rvalid), 64'd0);
        tick(); bus_if.slv_rvalid = 1'b0;                                       // cycle 3
        sb_check("t4");
        tick();                                                                 // cycle 4
        bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'h1111_1111;             // stray in IDLE
        tick(); bus_if.slv_rvalid = 1'b0;
        tick();
        chk_idle("t4_stray");
        chk("t4_stray_m0_rdata", 64'(bus_if.m0_rdata), 64'h5A5A_0F0F);
        chk("t4_stray_m1_rdata", 64'(bus_if.m1_rdata), 64'hAAAA_5555);

        // ---------------- asynchronous reset while in DELIVER
        bus_if.sel = 2'd1; bus_if.rd_req = 1'b1; bus_if.m0_rready = 1'b0;     // cycle 0
        tick(); bus_if.rd_req = 1'b0;                                           // cycle 1
        bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'h7777_8888;
        tick(); bus_if.slv_rvalid = 1'b0;                                       // cycle 2
        chk("t5_pre_m0_rvalid", 64'(bus_if.m0_rvalid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk_idle("t5_async");
        chk("t5_async_m0_rdata", 64'(bus_if.m0_rdata),    64'd0);
        chk("t5_async_m1_rdata", 64'(bus_if.m1_rdata),    64'd0);
        chk("t5_async_terr",     64'(bus_if.timeout_err), 64'd0);
        tick();
        rstn = 1'b1; bus_if.m0_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("t5_post");
        end
        bus_if.sel = 2'd1; bus_if.rd_req = 1'b1;
        sb_push(1'b0, 32'h0F0F_1234, 1'b0);
        tick(); bus_if.rd_req = 1'b0;
        tick(); bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'h0F0F_1234;
        tick(); bus_if.slv_rvalid = 1'b0;
        wait_deliver("t5_after", 20);
        tick();
        chk_idle("t5_after_idle");

        // ---------------- back-to-back reads, master 0 then master 1
        bus_if.m0_rready = 1'b1; bus_if.m1_rready = 1'b1;
        bus_if.sel = 2'd1; bus_if.rd_req = 1'b1;                                // cycle 0
        sb_push(1'b0, 32'h0101_0101, 1'b0);
        tick(); bus_if.rd_req = 1'b0;                                           // cycle 1
        bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'h0101_0101;
        tick(); bus_if.slv_rvalid = 1'b0;                                       // cycle 2: handshake
        sb_check("t6_a");
        tick();                                                                 // cycle 3: IDLE
        chk_idle("t6_gap");
        bus_if.sel = 2'd2; bus_if.rd_req = 1'b1;
        sb_push(1'b1, 32'h0202_0202, 1'b0);
        tick(); bus_if.rd_req = 1'b0;                                           // cycle 4
        chk("t6_b_busy", 64'(bus_if.busy), 64'd1);
        bus_if.slv_rvalid = 1'b1; bus_if.slv_rdata = 32'h0202_0202;
        tick(); bus_if.slv_rvalid = 1'b0;                                       // cycle 5
        sb_check("t6_b");
        chk("t6_m0_rdata_kept", 64'(bus_if.m0_rdata), 64'h0101_0101);
        tick();
        chk_idle("t6_end");

        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
